// File: rtl/arith_pkg.sv
// Shared encodings and Y-select helper for the arithmetic unit.
// Optional flag outputs are enabled by defining ARITH_FLAGS_EN.
package arith_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_ADD1 = 3'b001;
   localparam logic [2:0] OP_SUBB = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_TFR0 = 3'b100;
   localparam logic [2:0] OP_INC  = 3'b101;
   localparam logic [2:0] OP_DEC  = 3'b110;
   localparam logic [2:0] OP_TFR1 = 3'b111;

   typedef enum logic [1:0] {
      YSEL_B     = 2'b00,
      YSEL_NOT_B = 2'b01,
      YSEL_ZERO  = 2'b10,
      YSEL_ONES  = 2'b11
   } y_sel_e;

   // Width-independent: applied bit by bit so any WIDTH can reuse it.
   function automatic logic y_bit(input y_sel_e sel, input logic b_bit);
      logic r;
      r = 1'b0;
      case (sel)
         YSEL_B:     r = b_bit;
         YSEL_NOT_B: r = ~b_bit;
         YSEL_ZERO:  r = 1'b0;
         YSEL_ONES:  r = 1'b1;
         default:    r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/arith_unit_pipe_if.sv
// Operand/result handshake bundle for arith_unit_pipe.
// Flag signals exist only when ARITH_FLAGS_EN is defined.
interface arith_unit_pipe_if #(parameter int WIDTH = 8);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             s1;
   logic             s0;
   logic             cary_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] d;
   logic             carray_out;
`ifdef ARITH_FLAGS_EN
   logic             zero;
   logic             negative;
   logic             overflow;
`endif

   modport master (
      output in_valid, a, b, s1, s0, cary_in, out_ready,
      input  in_ready, out_valid, d, carray_out
`ifdef ARITH_FLAGS_EN
      , input zero, negative, overflow
`endif
   );

   modport slave (
      input  in_valid, a, b, s1, s0, cary_in, out_ready,
      output in_ready, out_valid, d, carray_out
`ifdef ARITH_FLAGS_EN
      , output zero, negative, overflow
`endif
   );

endinterface

// File: rtl/arith_core.sv
// Combinational WIDTH-bit ripple adder: {carry, sum} = a + y + cin.
// Flag outputs are generated only when ARITH_FLAGS_EN is defined.
module arith_core
   import arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             carry
`ifdef ARITH_FLAGS_EN
   ,
   output logic             zero,
   output logic             negative,
   output logic             overflow
`endif
);

   logic [WIDTH:0] c;

   // Generate/propagate carry chain; c[i] is the carry into bit i.
   always_comb begin
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < WIDTH; i++) begin
         c[i+1] = (a[i] & y[i]) | ((a[i] ^ y[i]) & c[i]);
      end
   end

   assign sum   = a ^ y ^ c[WIDTH-1:0];
   assign carry = c[WIDTH];

`ifdef ARITH_FLAGS_EN
   assign zero     = (sum == '0);
   assign negative = sum[WIDTH-1];
   assign overflow = (a[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
`endif

endmodule

// File: rtl/arith_unit_pipe.sv
// Two-stage pipelined arithmetic unit with valid/ready flow control and a retired counter.
// Defining ARITH_FLAGS_EN adds registered zero/negative/overflow flags.
module arith_unit_pipe
   import arith_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   arith_unit_pipe_if.slave bus,
   output logic [CNT_W-1:0] retired
);

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_y;
   logic             s1_cin;

   logic             s2_adv;
   logic             s1_adv;
   y_sel_e           y_sel;
   logic [WIDTH-1:0] y_in;

   logic [WIDTH-1:0] core_sum;
   logic             core_carry;
`ifdef ARITH_FLAGS_EN
   logic             core_zero;
   logic             core_negative;
   logic             core_overflow;
`endif

   // Stall propagates backwards combinationally; there is no skid buffer.
   assign s2_adv      = !bus.out_valid || bus.out_ready;
   assign s1_adv      = !s1_valid || s2_adv;
   assign bus.in_ready = s1_adv && !rst;

   always_comb begin
      y_sel = y_sel_e'({bus.s1, bus.s0});
      y_in  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         y_in[i] = y_bit(y_sel, bus.b[i]);
      end
   end

   // Stage 1 holds the operand and selected Y; an empty slot advances as a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_y     <= '0;
         s1_cin   <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_a   <= bus.a;
            s1_y   <= y_in;
            s1_cin <= bus.cary_in;
         end
      end
   end

   arith_core #(.WIDTH(WIDTH)) u_core (
      .a        (s1_a),
      .y        (s1_y),
      .cin      (s1_cin),
      .sum      (core_sum),
      .carry    (core_carry)
`ifdef ARITH_FLAGS_EN
      ,
      .zero     (core_zero),
      .negative (core_negative),
      .overflow (core_overflow)
`endif
   );

   // Stage 2 result registers drive the outputs and hold while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid  <= 1'b0;
         bus.d          <= '0;
         bus.carray_out <= 1'b0;
`ifdef ARITH_FLAGS_EN
         bus.zero       <= 1'b0;
         bus.negative   <= 1'b0;
         bus.overflow   <= 1'b0;
`endif
      end else if (s2_adv) begin
         bus.out_valid <= s1_valid;
         if (s1_valid) begin
            bus.d          <= core_sum;
            bus.carray_out <= core_carry;
`ifdef ARITH_FLAGS_EN
            bus.zero       <= core_zero;
            bus.negative   <= core_negative;
            bus.overflow   <= core_overflow;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         retired <= '0;
      end else if (bus.out_valid && bus.out_ready) begin
         retired <= retired + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_arith_unit_pipe.sv
// Directed self-checking bench for arith_unit_pipe (WIDTH=8, CNT_W=16).
// Flag checks are compiled in when ARITH_FLAGS_EN is defined.
module tb_arith_unit_pipe;
   import arith_pkg::*;

   localparam int WIDTH = 8;
   localparam int CNT_W = 16;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
      logic [7:0] d;
      logic       c;
      logic       z;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [CNT_W-1:0] retired;
   logic [CNT_W-1:0] exp_retired;
   int               checks = 0;
   int               errors = 0;

   arith_unit_pipe_if #(.WIDTH(WIDTH)) bus ();

   arith_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .retired (retired)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic [2:0] op);
      bus.in_valid = 1'b1;
      bus.a        = av;
      bus.b        = bv;
      {bus.s1, bus.s0, bus.cary_in} = op;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.a = '0;
      bus.b = '0;
      {bus.s1, bus.s0, bus.cary_in} = OP_ADD;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_in_ready_low: got %b expected 0", bus.in_ready);
      end
      rst = 1'b0;
      exp_retired = '0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
      end
      checks++;
      if (bus.d !== 8'h00 || bus.carray_out !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_d: got %h/%b expected 00/0", bus.d, bus.carray_out);
      end
      checks++;
      if (retired !== 16'd0) begin
         errors++; $display("[TB] FAIL reset_retired: got %0d expected 0", retired);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
      end
`ifdef ARITH_FLAGS_EN
      checks++;
      if ({bus.zero, bus.negative, bus.overflow} !== 3'b000) begin
         errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {bus.zero, bus.negative, bus.overflow});
      end
`endif
   endtask

   task automatic test_add;
      issue(8'h05, 8'h03, OP_ADD);
      tick();
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++; $display("[TB] FAIL add_latency: out_valid got %b expected 1", bus.out_valid);
      end
      checks++;
      if (bus.d !== 8'h08 || bus.carray_out !== 1'b0) begin
         errors++; $display("[TB] FAIL add_result: got %h/%b expected 08/0", bus.d, bus.carray_out);
      end
`ifdef ARITH_FLAGS_EN
      checks++;
      if (bus.zero !== 1'b0) begin
         errors++; $display("[TB] FAIL add_zero: got %b expected 0", bus.zero);
      end
`endif
      tick();
      exp_retired++;
      checks++;
      if (retired !== exp_retired || bus.out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL add_retired: got %0d/%b expected %0d/0", retired, bus.out_valid, exp_retired);
      end
   endtask

   task automatic test_sub_overflow;
      issue(8'h7F, 8'hFF, OP_SUB);
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.d !== 8'h80 || bus.carray_out !== 1'b0) begin
         errors++; $display("[TB] FAIL sub_result: got v=%b %h/%b expected v=1 80/0", bus.out_valid, bus.d, bus.carray_out);
      end
`ifdef ARITH_FLAGS_EN
      checks++;
      if (bus.overflow !== 1'b1 || bus.negative !== 1'b1 || bus.zero !== 1'b0) begin
         errors++; $display("[TB] FAIL sub_flags: got ovf=%b neg=%b z=%b expected 1 1 0", bus.overflow, bus.negative, bus.zero);
      end
`endif
      tick();
      exp_retired++;
      checks++;
      if (retired !== exp_retired) begin
         errors++; $display("[TB] FAIL sub_retired: got %0d expected %0d", retired, exp_retired);
      end
   endtask

   task automatic test_inc_dec;
      vec_t v [6];
      v[0] = '{a:8'hFF, b:8'h55, op:OP_INC,  d:8'h00, c:1'b1, z:1'b1};
      v[1] = '{a:8'h00, b:8'h55, op:OP_DEC,  d:8'hFF, c:1'b0, z:1'b0};
      v[2] = '{a:8'h3C, b:8'h55, op:OP_TFR1, d:8'h3C, c:1'b1, z:1'b0};
      v[3] = '{a:8'h05, b:8'h03, op:OP_ADD1, d:8'h09, c:1'b0, z:1'b0};
      v[4] = '{a:8'h05, b:8'h03, op:OP_SUBB, d:8'h01, c:1'b1, z:1'b0};
      v[5] = '{a:8'hAA, b:8'h55, op:OP_TFR0, d:8'hAA, c:1'b0, z:1'b0};
      for (int i = 0; i < 6; i++) begin
         issue(v[i].a, v[i].b, v[i].op);
         tick();
         checks++;
         if (bus.out_valid !== 1'b1 || bus.d !== v[i].d || bus.carray_out !== v[i].c) begin
            errors++;
            $display("[TB] FAIL op_vec%0d: got v=%b %h/%b expected v=1 %h/%b", i, bus.out_valid, bus.d, bus.carray_out, v[i].d, v[i].c);
         end
         checks++;
`ifdef ARITH_FLAGS_EN
         if (bus.zero !== v[i].z) begin
            errors++; $display("[TB] FAIL op_zero%0d: got %b expected %b", i, bus.zero, v[i].z);
         end
`else
         if ((bus.d == 8'h00) !== v[i].z) begin
            errors++; $display("[TB] FAIL op_zero%0d: got d=%h expected zero=%b", i, bus.d, v[i].z);
         end
`endif
         tick();
         exp_retired++;
      end
      checks++;
      if (retired !== exp_retired) begin
         errors++; $display("[TB] FAIL ops_retired: got %0d expected %0d", retired, exp_retired);
      end
   endtask

   task automatic test_back_to_back;
      int   sent = 0;
      int   got = 0;
      int   stalls = 0;
      bit   saw_full = 1'b0;
      logic exp_rdy;
      logic acc;
      logic ret;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
         bus.in_valid  = (sent < 4);
         bus.a         = 8'(sent);
         bus.b         = 8'h01;
         {bus.s1, bus.s0, bus.cary_in} = OP_ADD;
         bus.out_ready = (stalls >= 3);
         #1;
         exp_rdy = !(((sent - got) == 2) && !bus.out_ready);
         checks++;
         if (bus.in_ready !== exp_rdy) begin
            errors++; $display("[TB] FAIL bp_in_ready cyc%0d: got %b expected %b", cyc, bus.in_ready, exp_rdy);
         end
         if (bus.in_ready === 1'b0) saw_full = 1'b1;
         if (bus.out_valid && !bus.out_ready) begin
            stalls++;
            checks++;
            if (bus.d !== 8'h01) begin
               errors++; $display("[TB] FAIL bp_hold cyc%0d: got %h expected 01", cyc, bus.d);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (bus.d !== 8'(got + 1) || bus.carray_out !== 1'b0) begin
               errors++; $display("[TB] FAIL bp_order%0d: got %h/%b expected %h/0", got, bus.d, bus.carray_out, 8'(got + 1));
            end
         end
         acc = bus.in_valid && bus.in_ready;
         ret = bus.out_valid && bus.out_ready;
         @(posedge clk);
         #1;
         if (acc) sent++;
         if (ret) begin
            got++;
            exp_retired++;
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      checks++;
      if (got != 4) begin
         errors++; $display("[TB] FAIL bp_timeout: got %0d results expected 4", got);
      end
      checks++;
      if (!saw_full || stalls != 3) begin
         errors++; $display("[TB] FAIL bp_stall: full=%b stalls=%0d expected 1/3", saw_full, stalls);
      end
      checks++;
      if (retired !== exp_retired) begin
         errors++; $display("[TB] FAIL bp_retired: got %0d expected %0d", retired, exp_retired);
      end
   endtask

   task automatic test_reset_mid;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_retired = '0;
      bus.out_ready = 1'b1;
      issue(8'h10, 8'h01, OP_ADD);
      issue(8'h20, 8'h02, OP_ADD);
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++; $display("[TB] FAIL mid_inflight: out_valid got %b expected 1", bus.out_valid);
      end
      rst = 1'b1;
      bus.in_valid = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL mid_rst_priority: in_ready got %b expected 0", bus.in_ready);
      end
      tick();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || retired !== exp_retired) begin
         errors++; $display("[TB] FAIL mid_flush: got v=%b retired=%0d expected v=0 retired=0", bus.out_valid, retired);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (bus.out_valid !== 1'b0 || retired !== exp_retired) begin
            errors++; $display("[TB] FAIL mid_no_result%0d: got v=%b retired=%0d expected v=0 retired=0", i, bus.out_valid, retired);
         end
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_add();
      test_sub_overflow();
      test_inc_dec();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
